// File: rtl/sdram_pkg.sv
// Shared constants, request bundle and state type for the SDRAM request arbiter.
// Master IDs are 2-bit indices; the controller side uses one-hot encodings.
package sdram_pkg;
    localparam int NUM_MASTERS = 3;
    localparam int ADDR_W      = 26;
    localparam int BURST_WORDS = 16;
    localparam int ID_W        = 2;

    localparam logic [ID_W-1:0] MST_IFETCH = 2'd0;
    localparam logic [ID_W-1:0] MST_DATA   = 2'd1;
    localparam logic [ID_W-1:0] MST_VIDEO  = 2'd2;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic              burst;
        logic [3:0]        byte_enable;
        logic [31:0]       wdata;
    } req_bundle_t;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } arb_state_t;

    function automatic logic [NUM_MASTERS-1:0] id_onehot(input logic [ID_W-1:0] id);
        return NUM_MASTERS'(1) << id;
    endfunction

    function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] base, input int step);
        return ID_W'((int'(base) + step) % NUM_MASTERS);
    endfunction
endpackage

// File: rtl/sdram_id_fifo.sv
// FIFO of master IDs for accepted reads, in the order the controller will complete them.
// A pop frees a slot for a push in the same cycle, so push+pop on a full FIFO is legal.
module sdram_id_fifo
    import sdram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic [ID_W-1:0] head,
    output logic            empty,
    output logic            full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter putting three bus masters onto the SDRAM controller request port,
// with one outstanding read per master and in-order completion routing.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ID_FIFO_DEPTH = 4
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_MASTERS-1:0]              m_req,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  m_addr,
    input  logic [NUM_MASTERS-1:0]              m_write,
    input  logic [NUM_MASTERS-1:0]              m_burst,
    input  logic [NUM_MASTERS-1:0][3:0]         m_byte_enable,
    input  logic [NUM_MASTERS-1:0][31:0]        m_wdata,
    output logic [NUM_MASTERS-1:0]              m_ack,
    output logic [31:0]                         m_rdata,
    output logic [NUM_MASTERS-1:0]              m_rdvalid,
    output logic [NUM_MASTERS-1:0]              m_complete,
    output logic [NUM_MASTERS-1:0]              sdram_req,
    output logic [ADDR_W-1:0]                   sdram_addr,
    output logic                                sdram_write,
    output logic                                sdram_burst,
    output logic [3:0]                          sdram_byte_enable,
    output logic [31:0]                         sdram_wdata,
    input  logic                                sdram_ack,
    input  logic [31:0]                         sdram_rdata,
    input  logic [NUM_MASTERS-1:0]              sdram_rdvalid,
    input  logic                                sdram_complete
);
    arb_state_t             state;
    req_bundle_t            req_q;
    logic [ID_W-1:0]        grant_id;
    logic [ID_W-1:0]        rr_last;
    logic [NUM_MASTERS-1:0] read_pending;
    logic [NUM_MASTERS-1:0] eligible;
    logic                   pick_valid;
    logic [ID_W-1:0]        pick_id;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic [ID_W-1:0]        fifo_head;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [NUM_MASTERS-1:0] pending_set;
    logic [NUM_MASTERS-1:0] pending_clr;

    assign eligible = m_req & ~read_pending;

    // Scan from the farthest candidate down so the one right after rr_last wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_id    = '0;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (eligible[rr_next(rr_last, k)]) begin
                pick_valid = 1'b1;
                pick_id    = rr_next(rr_last, k);
            end
        end
    end

    assign accept      = (state == ST_GRANT) && sdram_ack && !reset;
    assign push        = accept && !req_q.write;
    assign pop         = sdram_complete && !fifo_empty && !reset;
    assign pending_set = push ? id_onehot(grant_id) : '0;
    assign pending_clr = pop ? id_onehot(fifo_head) : '0;

    assign m_ack      = accept ? sdram_req : '0;
    assign m_complete = pending_clr;
    assign m_rdvalid  = reset ? '0 : sdram_rdvalid;
    assign m_rdata    = sdram_rdata;

    assign sdram_addr        = req_q.addr;
    assign sdram_write       = req_q.write;
    assign sdram_burst       = req_q.burst;
    assign sdram_byte_enable = req_q.byte_enable;
    assign sdram_wdata       = req_q.wdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            sdram_req    <= '0;
            grant_id     <= '0;
            rr_last      <= MST_VIDEO;
            read_pending <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        req_q.addr        <= m_addr[pick_id];
                        req_q.write       <= m_write[pick_id];
                        req_q.burst       <= m_burst[pick_id];
                        req_q.byte_enable <= m_byte_enable[pick_id];
                        req_q.wdata       <= m_wdata[pick_id];
                        grant_id          <= pick_id;
                        sdram_req         <= id_onehot(pick_id);
                        state             <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Held indefinitely; the controller may stall across refresh.
                    if (sdram_ack) begin
                        rr_last   <= grant_id;
                        sdram_req <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            read_pending <= (read_pending & ~pending_clr) | pending_set;
        end
    end

    sdram_id_fifo #(
        .DEPTH (ID_FIFO_DEPTH)
    ) u_id_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .push_id (grant_id),
        .pop     (pop),
        .head    (fifo_head),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    a_complete_has_owner : assert property (@(posedge clock) disable iff (reset)
        sdram_complete |-> !fifo_empty);
    a_no_push_when_full : assert property (@(posedge clock) disable iff (reset)
        !(push && fifo_full && !pop));
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: a transaction-level model checked every cycle,
// plus hand-computed expectations on grant order, routing and timing.
module tb_sdram_arbiter;
    import sdram_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [2:0]        m_req = '0;
    logic [2:0][25:0]  m_addr = '0;
    logic [2:0]        m_write = '0;
    logic [2:0]        m_burst = '0;
    logic [2:0][3:0]   m_byte_enable = '0;
    logic [2:0][31:0]  m_wdata = '0;
    logic [2:0]        m_ack;
    logic [31:0]       m_rdata;
    logic [2:0]        m_rdvalid;
    logic [2:0]        m_complete;
    logic [2:0]        sdram_req;
    logic [25:0]       sdram_addr;
    logic              sdram_write;
    logic              sdram_burst;
    logic [3:0]        sdram_byte_enable;
    logic [31:0]       sdram_wdata;
    logic              sdram_ack = 1'b0;
    logic [31:0]       sdram_rdata = '0;
    logic [2:0]        sdram_rdvalid = '0;
    logic              sdram_complete = 1'b0;

    sdram_arbiter #(.ID_FIFO_DEPTH(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .m_req             (m_req),
        .m_addr            (m_addr),
        .m_write           (m_write),
        .m_burst           (m_burst),
        .m_byte_enable     (m_byte_enable),
        .m_wdata           (m_wdata),
        .m_ack             (m_ack),
        .m_rdata           (m_rdata),
        .m_rdvalid         (m_rdvalid),
        .m_complete        (m_complete),
        .sdram_req         (sdram_req),
        .sdram_addr        (sdram_addr),
        .sdram_write       (sdram_write),
        .sdram_burst       (sdram_burst),
        .sdram_byte_enable (sdram_byte_enable),
        .sdram_wdata       (sdram_wdata),
        .sdram_ack         (sdram_ack),
        .sdram_rdata       (sdram_rdata),
        .sdram_rdvalid     (sdram_rdvalid),
        .sdram_complete    (sdram_complete)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    function automatic void check(string name, longint unsigned act, longint unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int ohid(input logic [2:0] v);
        case (v)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 7;
        endcase
    endfunction

    // Transaction-level model: who owns the port, who has a read outstanding, completion order.
    int          mo_owner = -1;
    bit [2:0]    mo_pending = '0;
    int          mo_rr = 2;
    int          mo_q[$];
    logic [25:0] mo_addr;
    logic        mo_write;
    logic        mo_burst;
    logic [3:0]  mo_be;
    logic [31:0] mo_wdata;

    always @(posedge clock) begin
        int done;
        int c;
        cyc++;
        if (reset) begin
            mo_owner   = -1;
            mo_pending = '0;
            mo_q.delete();
            mo_rr      = 2;
        end else begin
            done = -1;
            if (sdram_complete && mo_q.size() > 0) done = mo_q.pop_front();
            if (mo_owner >= 0) begin
                if (sdram_ack) begin
                    mo_rr = mo_owner;
                    if (!mo_write) begin
                        mo_pending[mo_owner] = 1'b1;
                        mo_q.push_back(mo_owner);
                    end
                    mo_owner = -1;
                end
            end else begin
                for (int k = 1; k <= 3; k++) begin
                    c = (mo_rr + k) % 3;
                    if (mo_owner < 0 && m_req[c] && !mo_pending[c]) begin
                        mo_owner = c;
                        mo_addr  = m_addr[c];
                        mo_write = m_write[c];
                        mo_burst = m_burst[c];
                        mo_be    = m_byte_enable[c];
                        mo_wdata = m_wdata[c];
                    end
                end
            end
            if (done >= 0) mo_pending[done] = 1'b0;
        end
    end

    // Event logs for the hand-computed checks.
    int          ack_id[$];
    int          ack_cyc[$];
    logic [25:0] ack_addr[$];
    logic [31:0] ack_wdata[$];
    logic [3:0]  ack_be[$];
    logic        ack_wr[$];
    int          pres_id[$];
    int          pres_cyc[$];
    int          comp_id[$];
    int          comp_cyc[$];
    int          rdv_cnt[3];
    logic [31:0] last_rdata;
    logic [2:0]  prev_req = '0;

    always @(negedge clock) begin
        logic [2:0] e_req, e_ack, e_cmp, e_rdv;
        if (chk_en) begin
            e_req = (mo_owner >= 0) ? 3'(1 << mo_owner) : 3'b000;
            e_ack = (!reset && mo_owner >= 0 && sdram_ack) ? e_req : 3'b000;
            e_cmp = (!reset && sdram_complete && mo_q.size() > 0) ? 3'(1 << mo_q[0]) : 3'b000;
            e_rdv = reset ? 3'b000 : sdram_rdvalid;
            check("sdram_req", sdram_req, e_req);
            check("m_ack", m_ack, e_ack);
            check("m_complete", m_complete, e_cmp);
            check("m_rdvalid", m_rdvalid, e_rdv);
            if (e_rdv != 0) check("m_rdata", m_rdata, sdram_rdata);
            if (mo_owner >= 0) begin
                check("sdram_addr", sdram_addr, mo_addr);
                check("sdram_write", sdram_write, mo_write);
                check("sdram_burst", sdram_burst, mo_burst);
                check("sdram_be", sdram_byte_enable, mo_be);
                check("sdram_wdata", sdram_wdata, mo_wdata);
            end
        end
        if (m_ack != 0) begin
            ack_id.push_back(ohid(m_ack));
            ack_cyc.push_back(cyc);
            ack_addr.push_back(sdram_addr);
            ack_wdata.push_back(sdram_wdata);
            ack_be.push_back(sdram_byte_enable);
            ack_wr.push_back(sdram_write);
        end
        if (sdram_req != 0 && prev_req == 0) begin
            pres_id.push_back(ohid(sdram_req));
            pres_cyc.push_back(cyc);
        end
        prev_req = sdram_req;
        if (m_complete != 0) begin
            comp_id.push_back(ohid(m_complete));
            comp_cyc.push_back(cyc);
        end
        for (int i = 0; i < 3; i++) begin
            if (m_rdvalid[i]) begin
                rdv_cnt[i]++;
                last_rdata = m_rdata;
            end
        end
    end

    // Controller stand-in: acks after ack_delay extra presented cycles unless held off.
    bit ack_hold  = 1'b0;
    int ack_delay = 0;
    int present   = 0;
    always @(posedge clock) begin
        #1;
        if (sdram_req != 0) present++;
        else present = 0;
        sdram_ack = (sdram_req != 0) && !ack_hold && (present > ack_delay);
    end

    int last_start;

    task automatic clear_logs();
        ack_id.delete(); ack_cyc.delete(); ack_addr.delete(); ack_wdata.delete();
        ack_be.delete(); ack_wr.delete(); pres_id.delete(); pres_cyc.delete();
        comp_id.delete(); comp_cyc.delete();
        for (int i = 0; i < 3; i++) rdv_cnt[i] = 0;
    endtask

    task automatic raise_req(input int i, input bit wr, input bit bu, input logic [25:0] a,
                             input logic [3:0] be, input logic [31:0] d);
        m_addr[i] = a; m_write[i] = wr; m_burst[i] = bu;
        m_byte_enable[i] = be; m_wdata[i] = d; m_req[i] = 1'b1;
        last_start = cyc;
    endtask

    task automatic wait_ack(input int i);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (m_ack[i] !== 1'b1 && n < 200);
        check($sformatf("m%0d_ack_within_bound", i), m_ack[i], 1);
        @(posedge clock); #1;
        m_req[i] = 1'b0;
    endtask

    task automatic master_op(input int i, input bit wr, input bit bu, input logic [25:0] a,
                             input logic [3:0] be, input logic [31:0] d);
        @(posedge clock); #1;
        raise_req(i, wr, bu, a, be, d);
        wait_ack(i);
    endtask

    task automatic send_beats(input int id, input int beats);
        for (int b = 0; b < beats; b++) begin
            @(posedge clock); #1;
            sdram_rdvalid = 3'(1 << id);
            sdram_rdata   = 32'hA000_0000 + 32'(id << 8) + 32'(b);
        end
    endtask

    task automatic send_complete();
        @(posedge clock); #1;
        sdram_rdvalid  = '0;
        sdram_complete = 1'b1;
        @(posedge clock); #1;
        sdram_complete = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic wait_req(input logic [2:0] v, input string name);
        int n = 0;
        while (sdram_req !== v && n < 50) begin
            @(negedge clock);
            n++;
        end
        check(name, sdram_req, v);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk_en = 1'b1;
        reset  = 1'b0;
        @(negedge clock);
        check("rst_sdram_req", sdram_req, 3'b000);
        check("rst_m_ack", m_ack, 3'b000);
        check("rst_m_complete", m_complete, 3'b000);

        // Single write from master 1, ack one cycle after presentation.
        clear_logs();
        ack_delay = 1;
        master_op(1, 1'b1, 1'b0, 26'h0000100, 4'hF, 32'hDEADBEEF);
        repeat (3) @(negedge clock);
        ack_delay = 0;
        check("wr_ack_count", ack_id.size(), 1);
        check("wr_ack_id", ack_id[0], 1);
        check("wr_addr", ack_addr[0], 26'h0000100);
        check("wr_wdata", ack_wdata[0], 32'hDEADBEEF);
        check("wr_be", ack_be[0], 4'hF);
        check("wr_flag", ack_wr[0], 1);
        check("wr_req_latency", pres_cyc[0] - last_start, 1);
        check("wr_ack_delay", ack_cyc[0] - pres_cyc[0], 1);
        check("wr_no_complete", comp_id.size(), 0);

        // Round-robin among three simultaneous writers.
        apply_reset();
        clear_logs();
        fork
            master_op(0, 1'b1, 1'b0, 26'h0000010, 4'h1, 32'h1111_0000);
            master_op(1, 1'b1, 1'b0, 26'h0000020, 4'h3, 32'h2222_0000);
            master_op(2, 1'b1, 1'b0, 26'h0000030, 4'hC, 32'h3333_0000);
        join
        repeat (3) @(negedge clock);
        check("rr_count", ack_id.size(), 3);
        check("rr_first", ack_id[0], 0);
        check("rr_second", ack_id[1], 1);
        check("rr_third", ack_id[2], 2);
        check("rr_gap_01", ack_cyc[1] - ack_cyc[0], 2);
        check("rr_gap_12", ack_cyc[2] - ack_cyc[1], 2);

        // Burst read from master 2.
        apply_reset();
        clear_logs();
        master_op(2, 1'b0, 1'b1, 26'h0002000, 4'h0, 32'h0);
        send_beats(2, 16);
        send_complete();
        repeat (2) @(negedge clock);
        check("burst_beats_m2", rdv_cnt[2], 16);
        check("burst_beats_other", rdv_cnt[0] + rdv_cnt[1], 0);
        check("burst_last_rdata", last_rdata, 32'hA000_020F);
        check("burst_complete_count", comp_id.size(), 1);
        check("burst_complete_id", comp_id[0], 2);
        master_op(2, 1'b0, 1'b0, 26'h0002040, 4'h0, 32'h0);
        send_beats(2, 1);
        send_complete();
        repeat (2) @(negedge clock);
        check("burst_regrant_complete", comp_id.size(), 2);

        // Master 0 blocked by its own pending read; master 1 served meanwhile.
        apply_reset();
        clear_logs();
        master_op(0, 1'b0, 1'b0, 26'h0000300, 4'h0, 32'h0);
        fork
            master_op(0, 1'b0, 1'b0, 26'h0000304, 4'h0, 32'h0);
            master_op(1, 1'b1, 1'b0, 26'h0000400, 4'hF, 32'h5555_AAAA);
            begin
                repeat (8) @(negedge clock);
                send_beats(0, 1);
                send_complete();
            end
        join
        repeat (2) @(negedge clock);
        check("pend_pres_count", pres_id.size(), 3);
        check("pend_pres_0", pres_id[0], 0);
        check("pend_pres_1", pres_id[1], 1);
        check("pend_pres_2", pres_id[2], 0);
        check("pend_regrant_after_complete", pres_cyc[2] - comp_cyc[0], 2);
        send_beats(0, 1);
        send_complete();
        repeat (2) @(negedge clock);
        check("pend_complete_ids", {comp_id.size(), comp_id[0], comp_id[1]}, {32'd2, 32'd0, 32'd0});

        // Completion ordering with the second complete coinciding with a read ack.
        apply_reset();
        clear_logs();
        master_op(0, 1'b0, 1'b0, 26'h0000500, 4'h0, 32'h0);
        master_op(1, 1'b0, 1'b1, 26'h0000600, 4'h0, 32'h0);
        send_beats(0, 1);
        send_complete();
        ack_hold = 1'b1;
        fork
            master_op(2, 1'b0, 1'b0, 26'h0000700, 4'h0, 32'h0);
            begin
                wait_req(3'b100, "order_m2_presented");
                send_beats(1, 16);
                @(negedge clock);
                ack_hold = 1'b0;
                send_complete();
            end
        join
        repeat (2) @(negedge clock);
        check("order_comp_count", comp_id.size(), 2);
        check("order_comp_first", comp_id[0], 0);
        check("order_comp_second", comp_id[1], 1);
        check("order_ack_m2", ack_id[2], 2);
        check("order_coincide", ack_cyc[2], comp_cyc[1]);
        send_beats(2, 1);
        send_complete();
        repeat (2) @(negedge clock);
        check("order_comp_third", comp_id[2], 2);
        check("order_model_empty", mo_q.size(), 0);

        // Reset while master 1's write waits in GRANT, with master 0 holding a pending read.
        apply_reset();
        master_op(0, 1'b0, 1'b0, 26'h0000800, 4'h0, 32'h0);
        ack_hold = 1'b1;
        @(posedge clock); #1;
        raise_req(1, 1'b1, 1'b0, 26'h0000900, 4'hF, 32'hCAFE_F00D);
        wait_req(3'b010, "rstg_m1_presented");
        @(posedge clock); #1;
        reset = 1'b1;
        sdram_rdvalid = 3'b001;
        sdram_rdata = 32'h0BAD_0BAD;
        @(negedge clock);
        check("rstg_rdvalid_masked", m_rdvalid, 3'b000);
        @(posedge clock); #1;
        reset = 1'b0;
        sdram_rdvalid = '0;
        ack_hold = 1'b0;
        clear_logs();
        raise_req(0, 1'b0, 1'b0, 26'h0000A00, 4'h0, 32'h0);
        raise_req(2, 1'b0, 1'b0, 26'h0000B00, 4'h0, 32'h0);
        @(negedge clock);
        check("rstg_req_dropped", sdram_req, 3'b000);
        fork
            wait_ack(0);
            wait_ack(1);
            wait_ack(2);
        join
        repeat (2) @(negedge clock);
        check("rstg_ack_count", ack_id.size(), 3);
        check("rstg_first", ack_id[0], 0);
        check("rstg_second", ack_id[1], 1);
        check("rstg_third", ack_id[2], 2);
        send_beats(0, 1);
        send_complete();
        send_beats(2, 1);
        send_complete();
        repeat (2) @(negedge clock);
        check("rstg_comp_count", comp_id.size(), 2);
        check("rstg_comp_first", comp_id[0], 0);
        check("rstg_comp_second", comp_id[1], 2);

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Arbitrates three bus masters onto the single request port of the SDRAM controller: 0 = CPU instruction fetch, 1 = CPU data, 2 = video/blitter.
- Drives the controller's request/address/write/burst/byte-enable/wdata inputs.
- Consumes its ack/rdata/rdvalid/complete outputs and routes each back to the owning master.
- Uses round-robin priority, allows one outstanding read per master, and tracks completion order in an ID FIFO.

Parameters:
- NUM_MASTERS, 3, number of masters; fixed by the 3-bit one-hot sdram_req encoding.
- ADDR_W, 26, byte address width.
- ID_FIFO_DEPTH, 4, depth of the outstanding-read ID FIFO; must be >= NUM_MASTERS.

Ports:
- clock  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- m_req  in  3  per-master request; must be held with all fields stable until the matching m_ack.
- m_addr  in  3x26  per-master byte address.
- m_write  in  3  per-master 1 = write, 0 = read.
- m_burst  in  3  per-master 1 = 16-word burst read (ignored for writes).
- m_byte_enable  in  3x4  per-master write byte enables.
- m_wdata  in  3x32  per-master write data.
- m_ack  out  3  one-hot, single cycle; the request was accepted by the controller.
- m_rdata  out  32  read data, broadcast to all masters.
- m_rdvalid  out  3  one-hot; m_rdata is valid for that master.
- m_complete  out  3  one-hot, single cycle; the read transaction (single or burst) is finished.
- sdram_req  out  3  one-hot granted master, 0 = no request.
- sdram_addr  out  26  registered address of the granted master.
- sdram_write  out  1  registered write flag.
- sdram_burst  out  1  registered burst flag.
- sdram_byte_enable  out  4  registered byte enables.
- sdram_wdata  out  32  registered write data.
- sdram_ack  in  1  controller accepted the presented request (combinational in the controller).
- sdram_rdata  in  32  controller read data.
- sdram_rdvalid  in  3  one-hot master ID tagging sdram_rdata.
- sdram_complete  in  1  end of a read transaction; carries no ID.

Behaviour:
- Reset:
  - State goes to IDLE; sdram_req = 0; m_ack = 0; m_complete = 0; m_rdvalid = 0.
  - read_pending = 000; ID FIFO emptied; rr_last = 2, so master 0 has first priority.
  - Request data registers are don't-care.
  - Reset mid-GRANT drops the request the next cycle; in-flight read data after reset is discarded (m_rdvalid forced to 0 while reset is high).
- Eligibility: master i is eligible when m_req[i] && !read_pending[i].
- State IDLE:
  - If any master is eligible, pick the first eligible master scanning rr_last+1, rr_last+2, … (mod 3).
  - Register that master's addr/write/burst/byte_enable/wdata into the sdram_* registers and set sdram_req = one-hot(i) next cycle.
  - Go to GRANT.
- State GRANT:
  - sdram_* outputs are held constant.
  - On sdram_ack: m_ack[g] = 1 in the same cycle (combinational), rr_last <= g, sdram_req <= 0, state goes to IDLE.
  - If the accepted request was a read: read_pending[g] <= 1 and push g into the ID FIFO.
  - No timeout; GRANT waits indefinitely, including across controller refresh.
- Latency: m_req rising at cycle 0 → sdram_req asserted at cycle 1 → earliest m_ack at cycle 1. At least one idle cycle (sdram_req = 0) follows every ack.
- Read return:
  - m_rdvalid = sdram_rdvalid and m_rdata = sdram_rdata, both pass-through and combinational.
  - A single read produces 1 rdvalid beat; a burst produces 16.
- Completion:
  - On sdram_complete, pop the FIFO head h; m_complete[h] = 1 in the same cycle; read_pending[h] <= 0.
  - Push and pop in the same cycle are both performed, with occupancy unchanged.
  - sdram_complete with an empty FIFO: m_complete = 0 and a simulation assertion error fires.
  - A push when full cannot occur (at most 3 pending reads); this is covered by an assertion.
- Writes: no completion and no pending flag; a master may issue back-to-back writes, each separated by the idle cycle.

Decomposition:
- sdram_pkg:
  - NUM_MASTERS, ADDR_W and BURST_WORDS = 16.
  - Master index constants MST_IFETCH = 0, MST_DATA = 1, MST_VIDEO = 2.
  - Typedef for the registered request bundle (addr, write, burst, byte_enable, wdata).
  - Arbiter state enum.
- Sub-module sdram_id_fifo: synchronous FIFO of 2-bit master IDs, depth ID_FIFO_DEPTH, with push/pop/empty/full and simultaneous push+pop support.

Test Plan:
- Single write: master 1 writes addr 0x0000100, data 0xDEADBEEF, BE 0xF, with sdram_ack returned 1 cycle after sdram_req.
  - Expect sdram_req = 010, fields exactly as driven, m_ack = 010 for one cycle, and no m_complete.
- Round-robin: all three masters request writes at the same time, ack given on every presentation.
  - Expect grant order 0, 1, 2; each grant is separated by one sdram_req = 0 cycle.
- Burst read: master 2 issues a burst read at 0x0002000; the model returns 16 beats tagged 100, then complete.
  - Expect m_rdvalid = 100 exactly 16 times, then m_complete = 100 for one cycle, after which read_pending[2] clears.
- Pending block: master 0 issues a single read, then immediately requests again before complete.
  - Expect no second sdram_req for master 0 until a cycle after m_complete[0]; master 1's request is served in the interim.
- Completion ordering: master 0 reads, then master 1 burst-reads, with the two completes arriving in order and the second coinciding with master 2's read ack.
  - Expect m_complete order 001 then 010, master 2's ID pushed correctly, and FIFO occupancy consistent.
- Reset mid-GRANT: master 1 has a write presented and no ack when reset is asserted for 1 cycle.
  - Expect sdram_req = 0 the next cycle, pending flags and FIFO cleared, and master 0 granted first afterwards.
